parada_rampa_parcial: RTL and testbench
=======================================

// Module: parada_rampa_parcial
// PURPOSE
//  Soft-stop (ramp-down) controller for the motor driven by the partial soft-start ramp.
//  Once the motor runs at full power, a stop request steps it down 100% -> 50% -> 30% -> off,
//  holding each step for a programmable number of cycles.
//  Rapido shortens the dwell and Lento lengthens it.
//  Its out_* level lines are OR-ed with the start ramp's out_* lines at the power-stage driver.
// PARAMETERS
//  CNT_W         8   width of the dwell counter
//  DWELL_NORMAL  8   cycles per step, normal stop
//  DWELL_RAPIDO  2   cycles per step, fast stop
//  DWELL_LENTO   32  cycles per step, slow stop (every DWELL_* is >=1 and <= 2**CNT_W)
// PORTS
//  clk         in   1  clock; all state changes on the rising edge
//  reset       in   1  synchronous, active-high reset
//  en_marcha   in   1  start ramp has reached 100%; motor is running
//  Parar       in   1  stop request (level)
//  Rapido      in   1  fast-stop select, sampled only at stop acceptance
//  Lento       in   1  slow-stop select, sampled only at stop acceptance
//  Emergencia  in   1  immediate stop, overrides everything except reset
//  out_100     out  1  full-power command
//  out_50      out  1  50% power command
//  out_30      out  1  30% power command
//  ocupado     out  1  ramp-down in progress (STEP_50 or STEP_30)
//  fin_parada  out  1  one-cycle pulse: ramp completed normally
// BEHAVIOUR
//  - Reset: synchronous, active-high; wins over all inputs. Next edge -> IDLE, counter=0, every output 0.
//  - States (encoding in package): IDLE, RUN, STEP_50, STEP_30.
//  - Outputs are registered and derived from state only:
//      RUN -> out_100; STEP_50 -> out_50; STEP_30 -> out_30.
//      At most one out_* is high in any cycle; IDLE drives all three low.
//  - IDLE -> RUN: en_marcha=1. If Parar=1 in the same cycle, still go to RUN; the stop is taken next cycle.
//  - RUN -> STEP_50: Parar=1 sampled at edge N; out_50 high from N+1, out_100 low from N+1.
//    On that edge, latch D:
//      Rapido&~Lento -> DWELL_RAPIDO; Lento&~Rapido -> DWELL_LENTO; otherwise -> DWELL_NORMAL.
//    Load counter = D-1.
//  - RUN -> IDLE: en_marcha drops while Parar=0 (upstream abort). No fin_parada pulse.
//  - STEP_50: the counter decrements each cycle. At 0 -> STEP_30 and reload D-1.
//    Each step therefore lasts exactly D cycles.
//  - STEP_30: at counter 0 -> IDLE, and fin_parada=1 for exactly the first IDLE cycle.
//  - During STEP_50/STEP_30, Parar, en_marcha, Rapido and Lento are ignored; the latched D is held.
//  - Re-start: after reaching IDLE, en_marcha=1 re-enters RUN at the earliest on the cycle after fin_parada.
//  - Emergencia=1 in any state: next edge -> IDLE, counter cleared, all out_* 0, no fin_parada.
//  - Emergencia and Parar together in RUN: Emergencia wins.
//  - D=1: each step lasts 1 cycle, so the stop runs 2 cycles from acceptance to IDLE.
//  - Counter arithmetic is unsigned CNT_W bits. It never wraps: it is reloaded before decrementing below 0.
//  - ocupado = (state==STEP_50)|(state==STEP_30), registered alongside state.
// STRUCTURE
//  - Package motor_rampa_pkg:
//      state typedef (shared with the start ramp where applicable) and the IDLE/RUN/STEP_* encodings;
//      power-level constants (NIVEL_30, NIVEL_50, NIVEL_100);
//      default dwell constants.
//  - Sub-module contador_permanencia: loadable down-counter.
//      Ports: clk, reset, carga, valor[CNT_W], cero.
//      The FSM and output registers stay in this module.
// TESTING
//  1. Reset mid-STEP_50 (D=8, 3 cycles in) -> next edge: all out_* 0, ocupado 0, state IDLE,
//     no fin_parada.
//  2. Normal stop: en_marcha=1, then Parar=1 at edge N with Rapido=Lento=0
//     -> out_50 during N+1..N+8, out_30 during N+9..N+16, fin_parada at N+17 only.
//  3. Fast stop with Rapido=1 -> out_50 for 2 cycles, out_30 for 2 cycles.
//     Slow stop with Lento=1 -> 32 and 32 cycles.
//     Rapido=Lento=1 -> 8 and 8 cycles.
//  4. Rapido toggled during STEP_50 -> dwell unchanged (8 cycles).
//     Parar dropped mid-ramp -> ramp still completes.
//  5. Emergencia=1 during STEP_30 -> next edge all outputs 0, ocupado 0, fin_parada never asserted.
//     Emergencia+Parar in RUN -> IDLE directly.
//  6. en_marcha falls in RUN with Parar=0 -> IDLE with no pulse.
//     en_marcha=1 held through fin_parada -> RUN re-entered on the cycle after the pulse.
//     Check every cycle that at most one out_* is high.

Source files
------------

// File: rtl/parada_rampa_parcial_pkg.sv
// Shared definitions for the motor soft-start / soft-stop ramps: state encoding,
// one-hot power levels and default dwell times.
package motor_rampa_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    STEP_50 = 2'd2,
    STEP_30 = 2'd3
  } estado_t;

  // Power level as driven to the power stage: {out_100, out_50, out_30}
  typedef logic [2:0] nivel_t;

  localparam nivel_t NIVEL_OFF = 3'b000;
  localparam nivel_t NIVEL_30  = 3'b001;
  localparam nivel_t NIVEL_50  = 3'b010;
  localparam nivel_t NIVEL_100 = 3'b100;

  localparam int CNT_W_DEF        = 8;
  localparam int DWELL_NORMAL_DEF = 8;
  localparam int DWELL_RAPIDO_DEF = 2;
  localparam int DWELL_LENTO_DEF  = 32;

  function automatic nivel_t nivel_de(input estado_t estado);
    case (estado)
      RUN:     return NIVEL_100;
      STEP_50: return NIVEL_50;
      STEP_30: return NIVEL_30;
      default: return NIVEL_OFF;
    endcase
  endfunction

  // Exactly one of Rapido/Lento selects its dwell; both or neither gives normal.
  function automatic int sel_dwell(input logic rapido, input logic lento,
                                   input int normal, input int rap, input int len);
    if (rapido && !lento) return rap;
    if (lento && !rapido) return len;
    return normal;
  endfunction

endpackage

// File: rtl/parada_rampa_parcial_if.sv
// Control and power-level lines of the soft-stop controller.
interface parada_rampa_parcial_if;
  logic en_marcha;
  logic Parar;
  logic Rapido;
  logic Lento;
  logic Emergencia;
  logic out_100;
  logic out_50;
  logic out_30;
  logic ocupado;
  logic fin_parada;

  modport master (
    output en_marcha, Parar, Rapido, Lento, Emergencia,
    input  out_100, out_50, out_30, ocupado, fin_parada
  );

  modport slave (
    input  en_marcha, Parar, Rapido, Lento, Emergencia,
    output out_100, out_50, out_30, ocupado, fin_parada
  );
endinterface

// File: rtl/parada_rampa_parcial_contador_permanencia.sv
// Loadable down-counter that measures the dwell of each ramp step; it parks at
// zero instead of wrapping.
module contador_permanencia #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             carga,
  input  logic [CNT_W-1:0] valor,
  output logic             cero
);

  logic [CNT_W-1:0] cuenta_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      cuenta_q <= '0;
    end else if (carga) begin
      cuenta_q <= valor;
    end else if (cuenta_q != '0) begin
      cuenta_q <= cuenta_q - 1'b1;
    end
  end

  assign cero = (cuenta_q == '0);

endmodule

// File: rtl/parada_rampa_parcial.sv
// Soft-stop controller: steps a running motor 100% -> 50% -> 30% -> off, holding
// each step for a dwell chosen when the stop is accepted.
module parada_rampa_parcial
  import motor_rampa_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int DWELL_NORMAL = DWELL_NORMAL_DEF,
  parameter int DWELL_RAPIDO = DWELL_RAPIDO_DEF,
  parameter int DWELL_LENTO  = DWELL_LENTO_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  parada_rampa_parcial_if.slave  bus
);

  estado_t          estado_q, estado_d;
  logic [CNT_W-1:0] recarga_q, recarga_d;
  logic [CNT_W-1:0] valor;
  logic             carga;
  logic             cero;
  logic             fin_d;
  nivel_t           nivel_q;
  logic             ocupado_q;
  logic             fin_q;

  contador_permanencia #(.CNT_W(CNT_W)) u_contador (
    .clk   (clk),
    .reset (reset),
    .carga (carga),
    .valor (valor),
    .cero  (cero)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    estado_d  = estado_q;
    recarga_d = recarga_q;
    carga     = 1'b0;
    valor     = recarga_q;
    fin_d     = 1'b0;

    if (bus.Emergencia) begin
      estado_d = IDLE;
      carga    = 1'b1;
      valor    = '0;
    end else begin
      unique case (estado_q)
        IDLE: begin
          if (bus.en_marcha) estado_d = RUN;
        end
        RUN: begin
          if (bus.Parar) begin
            estado_d  = STEP_50;
            recarga_d = CNT_W'(sel_dwell(bus.Rapido, bus.Lento,
                                         DWELL_NORMAL, DWELL_RAPIDO, DWELL_LENTO) - 1);
            carga     = 1'b1;
            valor     = recarga_d;
          end else if (!bus.en_marcha) begin
            estado_d = IDLE;
          end
        end
        STEP_50: begin
          if (cero) begin
            estado_d = STEP_30;
            carga    = 1'b1;
          end
        end
        STEP_30: begin
          if (cero) begin
            estado_d = IDLE;
            fin_d    = 1'b1;
          end
        end
        default: estado_d = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with estado_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q  <= IDLE;
      recarga_q <= '0;
      nivel_q   <= NIVEL_OFF;
      ocupado_q <= 1'b0;
      fin_q     <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      recarga_q <= recarga_d;
      nivel_q   <= nivel_de(estado_d);
      ocupado_q <= (estado_d == STEP_50) || (estado_d == STEP_30);
      fin_q     <= fin_d;
    end
  end

  assign bus.out_100    = nivel_q[2];
  assign bus.out_50     = nivel_q[1];
  assign bus.out_30     = nivel_q[0];
  assign bus.ocupado    = ocupado_q;
  assign bus.fin_parada = fin_q;

endmodule

// File: tb/tb_parada_rampa_parcial.sv
// Scoreboard bench for parada_rampa_parcial: a schedule-based reference model
// predicts the output vector after every edge; a monitor compares on negedges.
module tb_parada_rampa_parcial;

  localparam int DN = 8;
  localparam int DR = 2;
  localparam int DL = 32;

  logic clk = 1'b0;
  logic reset;

  parada_rampa_parcial_if bus ();

  parada_rampa_parcial #(
    .CNT_W        (8),
    .DWELL_NORMAL (DN),
    .DWELL_RAPIDO (DR),
    .DWELL_LENTO  (DL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected {out_100, out_50, out_30, ocupado, fin_parada} after each edge.
  logic [4:0] esperado[$];

  // Reference model: a list of remaining power levels for an accepted stop
  // (50s, then 30s, then 0 meaning "finished").
  int plan[$];
  bit marcha = 1'b0;

  task automatic check(input string nombre, input logic [31:0] actual,
                       input logic [31:0] requerido);
    n_checks++;
    if (actual !== requerido) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b required %b", nombre, $time, actual, requerido);
    end
  endtask

  task automatic step(input logic r, input logic en, input logic pa,
                      input logic ra, input logic le, input logic em);
    int  nivel;
    bit  fin;
    logic [4:0] exp_v;
    reset          = r;
    bus.en_marcha  = en;
    bus.Parar      = pa;
    bus.Rapido     = ra;
    bus.Lento      = le;
    bus.Emergencia = em;
    nivel = 0;
    fin   = 1'b0;
    if (r || em) begin
      plan.delete();
      marcha = 1'b0;
    end else if (plan.size() > 0) begin
      nivel = plan.pop_front();
      if (nivel == 0) begin
        fin    = 1'b1;
        marcha = 1'b0;
      end
    end else if (marcha) begin
      if (pa) begin
        int d;
        d = (ra && !le) ? DR : ((le && !ra) ? DL : DN);
        for (int i = 0; i < d; i++) plan.push_back(50);
        for (int i = 0; i < d; i++) plan.push_back(30);
        plan.push_back(0);
        nivel = plan.pop_front();
      end else if (!en) begin
        marcha = 1'b0;
      end else begin
        nivel = 100;
      end
    end else if (en) begin
      marcha = 1'b1;
      nivel  = 100;
    end
    exp_v = {nivel == 100, nivel == 50, nivel == 30, (nivel == 50) || (nivel == 30), fin};
    @(posedge clk);
    esperado.push_back(exp_v);
    #1;
  endtask

  task automatic repetir(input int n, input logic en, input logic pa,
                         input logic ra, input logic le);
    for (int i = 0; i < n; i++) step(1'b0, en, pa, ra, le, 1'b0);
  endtask

  // Monitor: one comparison per edge, plus the exclusive-level check.
  initial begin
    logic [4:0] exp_v;
    forever begin
      @(negedge clk);
      if (esperado.size() > 0) begin
        exp_v = esperado.pop_front();
        check("salidas", 32'({bus.out_100, bus.out_50, bus.out_30, bus.ocupado, bus.fin_parada}),
              32'(exp_v));
        check("nivel_exclusivo", 32'($onehot0({bus.out_100, bus.out_50, bus.out_30})), 32'd1);
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.en_marcha = 1'b0; bus.Parar = 1'b0; bus.Rapido = 1'b0;
    bus.Lento = 1'b0; bus.Emergencia = 1'b0;

    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);

    // Reset three cycles into STEP_50
    repetir(2, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    repetir(3, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    repetir(3, 0, 0, 0, 0);

    // Normal stop, Parar held, en_marcha held through fin_parada (re-start)
    repetir(2, 1, 0, 0, 0);
    repetir(20, 1, 1, 0, 0);
    repetir(3, 1, 0, 0, 0);
    repetir(2, 0, 0, 0, 0);

    // Fast, slow and both-selected stops
    repetir(2, 1, 0, 0, 0); step(0, 1, 1, 1, 0, 0); repetir(7, 0, 0, 0, 0);
    repetir(2, 1, 0, 0, 0); step(0, 1, 1, 0, 1, 0); repetir(67, 0, 0, 0, 0);
    repetir(2, 1, 0, 0, 0); step(0, 1, 1, 1, 1, 0); repetir(19, 0, 0, 0, 0);

    // Rapido toggled and Parar dropped mid-ramp
    repetir(2, 1, 0, 0, 0); step(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 19; i++) step(0, i[0], 1'b0, ~i[0], 1'b0, 1'b0);

    // Emergencia in STEP_30, then Emergencia with Parar in RUN
    repetir(2, 1, 0, 0, 0); step(0, 1, 1, 0, 0, 0);
    repetir(10, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    repetir(10, 0, 0, 0, 0);
    repetir(2, 1, 0, 0, 0); step(0, 1, 1, 0, 0, 1); repetir(3, 0, 0, 0, 0);

    // Upstream abort from RUN
    repetir(3, 1, 0, 0, 0); repetir(3, 0, 0, 0, 0);

    // Biased random traffic
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(999) < 4, $urandom_range(9) < 8, $urandom_range(9) == 0,
           1'($urandom), 1'($urandom), $urandom_range(199) == 0);
    end

    @(negedge clk);
    #1;
    check("cola_vacia", 32'(esperado.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
